// File: rtl/capture2ram_if.sv
// Pixel-stream and line-buffer write bundle between the video source, capture2ram and the RAM.
// master = source/RAM side, slave = capture2ram.
interface capture2ram_if;
    logic [23:0] pixel_in;
    logic        pixel_en;
    logic        hsync_in;
    logic        vsync_in;
    logic        line_doubler;
    logic [23:0] wrdata;
    logic [14:0] wraddr;
    logic        wren;
    logic        starttrigger;
    logic        locked;

    modport master (
        output pixel_in, pixel_en, hsync_in, vsync_in, line_doubler,
        input  wrdata, wraddr, wren, starttrigger, locked
    );

    modport slave (
        input  pixel_in, pixel_en, hsync_in, vsync_in, line_doubler,
        output wrdata, wraddr, wren, starttrigger, locked
    );
endinterface

// File: rtl/capture2ram.sv
// Locates the active window of the Dreamcast pixel stream, writes it into the line-buffer RAM
// as a ring of lines and pulses starttrigger once enough lines of a frame are buffered.
module capture2ram #(
    parameter logic [11:0] H_ACTIVE_START     = 12'd0,
    parameter int          H_ACTIVE_WIDTH     = 640,
    parameter logic [10:0] V_ACTIVE_START     = 11'd0,
    parameter int          V_ACTIVE_LINES     = 480,
    parameter int          BUFFER_LINE_LENGTH = 640,
    parameter int          RAM_NUMWORDS       = 30720,
    parameter int          TRIGGER_LINE       = 4
) (
    input  logic         clock,
    input  logic         reset,
    capture2ram_if.slave bus
);
    localparam logic [12:0] H_WIDTH    = 13'(H_ACTIVE_WIDTH);
    localparam logic [11:0] V_FULL     = 12'(V_ACTIVE_LINES);
    localparam logic [11:0] V_HALF     = 12'(V_ACTIVE_LINES >> 1);
    localparam logic [14:0] LINE_LEN   = 15'(BUFFER_LINE_LENGTH);
    localparam logic [14:0] BASE_LIMIT = 15'(RAM_NUMWORDS - BUFFER_LINE_LENGTH);
    localparam logic [7:0]  TRIG_LINES = 8'(TRIGGER_LINE);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_CAPTURE = 1'b1} state_t;

    state_t      state_q, state_d;
    logic        hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
    logic        ld_meta_q, ld_meta_d, ld_sync_q, ld_sync_d;
    logic [11:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic [14:0] line_base_q, line_base_d;
    logic [7:0]  written_lines_q, written_lines_d;
    logic        trig_done_q, trig_done_d;
    logic        line_wrote_q, line_wrote_d;
    logic        wren_q, wren_d;
    logic [23:0] wrdata_q, wrdata_d;
    logic [14:0] wraddr_q, wraddr_d;
    logic        trig_q, trig_d;

    logic        hs_fall_s, vs_fall_s, ld_edge_s, x_in_s, y_in_s, write_s, advance_s;
    logic [12:0] x_off_s;
    logic [11:0] y_off_s, active_lines_s;

    // Next-state logic: sync edges, counters, window decode, ring advance, trigger and FSM.
    always_comb begin
        hs_fall_s      = hs_prev_q & ~bus.hsync_in;
        vs_fall_s      = vs_prev_q & ~bus.vsync_in;
        ld_edge_s      = ld_meta_q ^ ld_sync_q;
        active_lines_s = ld_sync_q ? V_HALF : V_FULL;
        x_off_s        = {1'b0, x_q} - {1'b0, H_ACTIVE_START};
        y_off_s        = {1'b0, y_q} - {1'b0, V_ACTIVE_START};
        x_in_s         = ~x_off_s[12] && (x_off_s < H_WIDTH);
        y_in_s         = ~y_off_s[11] && (y_off_s < active_lines_s);
        write_s        = bus.pixel_en && x_in_s && y_in_s && (state_q == ST_CAPTURE) && !ld_edge_s;
        advance_s      = hs_fall_s && y_in_s && (line_wrote_q || write_s);

        hs_prev_d       = bus.hsync_in;
        vs_prev_d       = bus.vsync_in;
        ld_meta_d       = bus.line_doubler;
        ld_sync_d       = ld_meta_q;
        state_d         = state_q;
        line_base_d     = line_base_q;
        written_lines_d = written_lines_q;
        trig_done_d     = trig_done_q;
        trig_d          = 1'b0;
        wren_d          = write_s;
        wrdata_d        = wrdata_q;
        wraddr_d        = wraddr_q;

        if (hs_fall_s) begin
            x_d = 12'd0;
        end else if (bus.pixel_en && (x_q != 12'hFFF)) begin
            x_d = x_q + 12'd1;
        end else begin
            x_d = x_q;
        end

        // vsync fall outranks a coincident hsync fall
        if (vs_fall_s) begin
            y_d = 11'd0;
        end else if (hs_fall_s && (y_q != 11'h7FF)) begin
            y_d = y_q + 11'd1;
        end else begin
            y_d = y_q;
        end

        if (hs_fall_s || vs_fall_s) begin
            line_wrote_d = 1'b0;
        end else if (write_s) begin
            line_wrote_d = 1'b1;
        end else begin
            line_wrote_d = line_wrote_q;
        end

        if (write_s) begin
            wrdata_d = bus.pixel_in;
            wraddr_d = line_base_q + {2'b00, x_off_s};
        end else begin
            wrdata_d = wrdata_q;
            wraddr_d = wraddr_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (vs_fall_s) begin
                    state_d         = ST_CAPTURE;
                    line_base_d     = 15'd0;
                    written_lines_d = 8'd0;
                    trig_done_d     = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                if (vs_fall_s) begin
                    line_base_d     = 15'd0;
                    written_lines_d = 8'd0;
                    trig_done_d     = 1'b0;
                end else begin
                    // same wrap rule as the reader so both sides agree on line bases
                    if (advance_s) begin
                        written_lines_d = (written_lines_q != 8'hFF) ? written_lines_q + 8'd1 : written_lines_q;
                        line_base_d     = (line_base_q < BASE_LIMIT) ? line_base_q + LINE_LEN : 15'd0;
                    end else begin
                        line_base_d = line_base_q;
                    end
                    if ((written_lines_q == TRIG_LINES) && !trig_done_q) begin
                        trig_d      = 1'b1;
                        trig_done_d = 1'b1;
                    end else begin
                        trig_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (ld_edge_s) begin
            state_d = ST_IDLE;
            trig_d  = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            hs_prev_q       <= 1'b1;
            vs_prev_q       <= 1'b1;
            ld_meta_q       <= 1'b0;
            ld_sync_q       <= 1'b0;
            x_q             <= 12'd0;
            y_q             <= 11'd0;
            line_base_q     <= 15'd0;
            written_lines_q <= 8'd0;
            trig_done_q     <= 1'b0;
            line_wrote_q    <= 1'b0;
            wren_q          <= 1'b0;
            wrdata_q        <= 24'd0;
            wraddr_q        <= 15'd0;
            trig_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            hs_prev_q       <= hs_prev_d;
            vs_prev_q       <= vs_prev_d;
            ld_meta_q       <= ld_meta_d;
            ld_sync_q       <= ld_sync_d;
            x_q             <= x_d;
            y_q             <= y_d;
            line_base_q     <= line_base_d;
            written_lines_q <= written_lines_d;
            trig_done_q     <= trig_done_d;
            line_wrote_q    <= line_wrote_d;
            wren_q          <= wren_d;
            wrdata_q        <= wrdata_d;
            wraddr_q        <= wraddr_d;
            trig_q          <= trig_d;
        end
    end

    assign bus.wren         = wren_q;
    assign bus.wrdata       = wrdata_q;
    assign bus.wraddr       = wraddr_q;
    assign bus.starttrigger = trig_q;
    assign bus.locked       = (state_q == ST_CAPTURE);
endmodule
